// File: rtl/cpu_types_pkg.sv
// Shared CPU type package: instruction-cache state encoding, default cache
// geometry and a helper sizing way-select fields.
package cpu_types_pkg;

  typedef enum logic {IC_IDLE, IC_FILL} icache_state_t;

  localparam int unsigned ICACHE_WAYS  = 2;
  localparam int unsigned ICACHE_IDX_W = 4;
  localparam int unsigned ICACHE_BLK_W = 1;

  // Width of a way-select field; a direct-mapped cache still carries one bit.
  function automatic int unsigned way_bits(input int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/icache_nway_victim_sel.sv
// icache_victim_sel: per-set replacement state and victim choice.
// Ports:
//   i_clk, i_rst_n      clock, async active-low reset
//   i_idx, i_valid      lookup set and its per-way valid bits
//   i_upd_en            update replacement state this cycle
//   i_upd_fill          update is a fill completion (else a hit)
//   i_upd_idx/i_upd_way set and way being touched
//   o_victim_c          lowest invalid way, else LRU (2-way) / pointer (4-way)
module icache_victim_sel
  import cpu_types_pkg::*;
#(
  parameter int unsigned WAYS  = ICACHE_WAYS,
  parameter int unsigned IDX_W = ICACHE_IDX_W,
  parameter int unsigned WAY_W = way_bits(WAYS)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [WAYS-1:0]  i_valid,
  input  logic             i_upd_en,
  input  logic             i_upd_fill,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  logic [WAY_W-1:0] i_upd_way,
  output logic [WAY_W-1:0] o_victim_c
);

  localparam int unsigned SETS = 1 << IDX_W;

  logic [WAY_W-1:0] w_repl_way;

  generate
    if (WAYS == 2) begin : g_lru
      // r_lru[set] names the least-recently-used way
      logic [SETS-1:0] r_lru;
      logic            w_unused;
      assign w_unused = i_upd_fill;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)      r_lru <= '0;
        else if (i_upd_en) r_lru[i_upd_idx] <= ~i_upd_way[0];
      end
      assign w_repl_way = WAY_W'(r_lru[i_idx]);
    end else if (WAYS == 4) begin : g_rr
      // round-robin pointer advances only when a line is filled
      logic [SETS-1:0][1:0] r_ptr;
      logic                 w_unused;
      assign w_unused = ^i_upd_way;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                    r_ptr <= '0;
        else if (i_upd_en && i_upd_fill) r_ptr[i_upd_idx] <= r_ptr[i_upd_idx] + 2'd1;
      end
      assign w_repl_way = WAY_W'(r_ptr[i_idx]);
    end else begin : g_dm
      logic w_unused;
      assign w_unused   = ^{i_clk, i_rst_n, i_upd_en, i_upd_fill, i_upd_idx, i_upd_way};
      assign w_repl_way = '0;
    end
  endgenerate

  // Invalid ways are always preferred; scan high to low so the lowest wins.
  always_comb begin
    o_victim_c = w_repl_way;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!i_valid[w]) o_victim_c = WAY_W'(w);
    end
  end

endmodule

// File: rtl/icache_nway.sv
// icache_nway: N-way set-associative instruction cache with multi-word blocks.
// Hits return combinationally in IC_IDLE; misses run a sequential block fill.
// Ports:
//   CLK, nRST                      clock, async active-low reset
//   imemREN, imemaddr              datapath fetch request / byte address
//   ihit, imemload                 hit flag and instruction word (same cycle)
//   iflush                         invalidate all lines (pended during a fill)
//   iREN, iaddr, iwait, iload      memory-controller instruction port
//   hit_count, miss_count          saturating statistics, only when
//                                  ICACHE_STATS_EN is defined
module icache_nway
  import cpu_types_pkg::*;
#(
  parameter int unsigned WAYS  = ICACHE_WAYS,
  parameter int unsigned IDX_W = ICACHE_IDX_W,
  parameter int unsigned BLK_W = ICACHE_BLK_W
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        iflush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  , output logic [31:0] hit_count
  , output logic [31:0] miss_count
`endif
);

  localparam int unsigned TAG_W = 32 - IDX_W - BLK_W - 2;
  localparam int unsigned SETS  = 1 << IDX_W;
  localparam int unsigned WORDS = 1 << BLK_W;
  localparam int unsigned CNT_W = (BLK_W == 0) ? 1 : BLK_W;
  localparam int unsigned WAY_W = way_bits(WAYS);

  icache_state_t r_state;
  logic [SETS-1:0][WAYS-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [WAYS][SETS];
  logic [31:0]      r_data [WAYS][SETS][WORDS];
  logic [TAG_W-1:0] r_ltag;
  logic [IDX_W-1:0] r_lidx;
  logic [WAY_W-1:0] r_victim;
  logic [CNT_W-1:0] r_cnt;
  logic             r_flush_pend;

  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_idx;
  logic [CNT_W-1:0] w_blk;
  logic             w_hit_any;
  logic [WAY_W-1:0] w_hit_way;
  logic [31:0]      w_hit_word;
  logic [WAY_W-1:0] w_victim;
  logic             w_miss;
  logic             w_last;
  logic             w_fill_done;

  // Address fields; byte offset is ignored.
  assign w_tag = TAG_W'(imemaddr >> (IDX_W + BLK_W + 2));
  assign w_idx = IDX_W'(imemaddr >> (BLK_W + 2));
  assign w_blk = (BLK_W == 0) ? '0 : CNT_W'(imemaddr >> 2);

  // Tag compare across all ways of the addressed set.
  always_comb begin
    w_hit_any  = 1'b0;
    w_hit_way  = '0;
    w_hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w][w_idx] == w_tag)) begin
        w_hit_any  = 1'b1;
        w_hit_way  = WAY_W'(w);
        w_hit_word = r_data[w][w_idx][w_blk];
      end
    end
  end

  // A flush cycle never reports a hit, even if the line matches.
  assign ihit        = (r_state == IC_IDLE) && imemREN && w_hit_any && !iflush;
  assign imemload    = ihit ? w_hit_word : 32'd0;
  assign w_miss      = (r_state == IC_IDLE) && imemREN && !w_hit_any && !iflush;
  assign w_last      = (r_cnt == CNT_W'(WORDS - 1));
  assign w_fill_done = (r_state == IC_FILL) && !iwait && w_last;

  assign iREN  = (r_state == IC_FILL);
  assign iaddr = (r_state != IC_FILL) ? 32'd0 :
                 ((32'(r_ltag) << (IDX_W + BLK_W + 2)) |
                  (32'(r_lidx) << (BLK_W + 2)) |
                  ((BLK_W == 0) ? 32'd0 : (32'(r_cnt) << 2)));

  icache_victim_sel #(
    .WAYS  (WAYS),
    .IDX_W (IDX_W),
    .WAY_W (WAY_W)
  ) u_victim_sel (
    .i_clk      (CLK),
    .i_rst_n    (nRST),
    .i_idx      (w_idx),
    .i_valid    (r_valid[w_idx]),
    .i_upd_en   (ihit || w_fill_done),
    .i_upd_fill (w_fill_done),
    .i_upd_idx  (w_fill_done ? r_lidx : w_idx),
    .i_upd_way  (w_fill_done ? r_victim : w_hit_way),
    .o_victim_c (w_victim)
  );

  // Control state: IDLE lookup / miss capture, FILL word sequencing.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= IC_IDLE;
      r_valid      <= '0;
      r_ltag       <= '0;
      r_lidx       <= '0;
      r_victim     <= '0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      case (r_state)
        IC_IDLE: begin
          if (iflush) begin
            r_valid <= '0;
          end else if (w_miss) begin
            r_ltag   <= w_tag;
            r_lidx   <= w_idx;
            r_victim <= w_victim;
            r_cnt    <= '0;
            r_state  <= IC_FILL;
          end
        end
        IC_FILL: begin
          if (iflush) r_flush_pend <= 1'b1;
          if (!iwait) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_state <= IC_IDLE;
              // a flush seen during the fill also kills the new line
              if (r_flush_pend || iflush) begin
                r_valid      <= '0;
                r_flush_pend <= 1'b0;
              end else begin
                r_valid[r_lidx][r_victim] <= 1'b1;
              end
            end
          end
        end
        default: r_state <= IC_IDLE;
      endcase
    end
  end

  // Data and tag arrays need no reset; validity is tracked separately.
  always_ff @(posedge CLK) begin
    if ((r_state == IC_FILL) && !iwait) begin
      r_data[r_victim][r_lidx][r_cnt] <= iload;
      if (w_last) r_tag[r_victim][r_lidx] <= r_ltag;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  // Saturating counters; survive flushes, cleared only by reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (ihit && (r_hit_cnt != 32'hFFFF_FFFF))    r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_miss && (r_miss_cnt != 32'hFFFF_FFFF)) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`endif

endmodule

// File: tb/tb_icache_nway.sv
// Self-checking bench for icache_nway (default geometry: 2 ways, 16 sets,
// 2-word blocks). A behavioural memory with a 2-cycle wait serves fills.
// Statistics ports are exercised when ICACHE_STATS_EN is defined.
module tb_icache_nway;

  localparam int unsigned WORDS = 2;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iflush;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache_nway dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iflush   (iflush),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
`ifdef ICACHE_STATS_EN
    , .hit_count  (hit_count)
    , .miss_count (miss_count)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int m_hits   = 0;
  int m_miss   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] addr_q[$];

  typedef struct {
    logic [31:0] addr;
    bit          miss;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEAD_BEEF;
    if (a == 32'h44) return 32'h1234_5678;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input string why);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s", nm, why);
  endtask

  // Memory side of a fill: 2 wait cycles per word, optional iflush pulse.
  task automatic serve_fill(input string nm, input int flush_cyc);
    int wcnt = 0;
    int c    = 0;
    while (iREN && c < 40) begin
      iwait  = (wcnt < 2);
      iload  = iwait ? 32'h0 : mem_word(iaddr);
      iflush = (c == flush_cyc);
      @(negedge CLK);
      if (!iwait) begin
        if (addr_q.size() == 0) fail_now({nm, "_iaddr"}, "unexpected extra word request");
        else chk({nm, "_iaddr"}, iaddr, addr_q.pop_front());
        wcnt = 0;
      end else begin
        wcnt++;
      end
      @(posedge CLK); #1;
      c++;
    end
    iwait  = 1'b1;
    iload  = 32'h0;
    iflush = 1'b0;
    if (c >= 40) fail_now({nm, "_fill"}, "fill did not finish within 40 cycles");
    if (addr_q.size() != 0) begin
      fail_now({nm, "_fill"}, "fill ended before all block words were requested");
      addr_q.delete();
    end
  endtask

  // One fetch: hit immediately, or miss, fill, then hit on the first IDLE cycle.
  task automatic fetch(input logic [31:0] a, input bit exp_miss, input string nm);
    logic [31:0] base;
    bit          first_hit;
    @(posedge CLK); #1;
    imemREN  = 1'b1;
    imemaddr = a;
    exp_q.push_back(mem_word(a & ~32'h3));
    @(negedge CLK);
    first_hit = ihit;
    chk({nm, "_hit_now"}, 32'(ihit), 32'(!exp_miss));
    if (!first_hit) begin
      m_miss++;
      base = a & ~(32'(WORDS * 4) - 32'd1);
      for (int k = 0; k < WORDS; k++) addr_q.push_back(base + 32'(k * 4));
      @(posedge CLK); #1;
      chk({nm, "_iren"}, 32'(iREN), 32'd1);
      serve_fill(nm, -1);
      @(negedge CLK);
    end
    if (ihit) begin
      m_hits++;
      chk({nm, "_data"}, imemload, exp_q.pop_front());
      chk({nm, "_iren_idle"}, 32'(iREN), 32'd0);
    end else begin
      fail_now({nm, "_data"}, "no hit after fill");
      exp_q.delete();
    end
    @(posedge CLK); #1;
    imemREN = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = 32'h0;
    iflush   = 1'b0;
    iwait    = 1'b1;
    iload    = 32'h0;

    // Lookup/replacement sequence from an empty cache.
    vecs.push_back('{32'h0000_0040, 1'b1, "cold_40"});
    vecs.push_back('{32'h0000_0044, 1'b0, "hit_44"});
    vecs.push_back('{32'h0000_0440, 1'b1, "fill_440"});
    vecs.push_back('{32'h0000_0040, 1'b0, "touch_40"});
    vecs.push_back('{32'h0000_0042, 1'b0, "unaligned_42"});
    vecs.push_back('{32'h0000_0840, 1'b1, "evict_440"});
    vecs.push_back('{32'h0000_0040, 1'b0, "keep_40"});
    vecs.push_back('{32'h0000_0440, 1'b1, "refetch_440"});
    vecs.push_back('{32'h0000_0844, 1'b1, "evicted_844"});
    vecs.push_back('{32'h0000_1000, 1'b1, "set0_1000"});
    vecs.push_back('{32'h0000_1004, 1'b0, "set0_1004"});
    vecs.push_back('{32'h0000_003C, 1'b1, "blk1_3c"});
    vecs.push_back('{32'h0000_0038, 1'b0, "blk0_38"});

    #12;
    chk("rst_ihit", 32'(ihit), 32'd0);
    chk("rst_iren", 32'(iREN), 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    chk("rst_load", imemload, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    chk("post_rst_iren", 32'(iREN), 32'd0);

    foreach (vecs[i]) fetch(vecs[i].addr, vecs[i].miss, vecs[i].name);

    // Flush in IDLE: matching line reports no hit in the flush cycle.
    fetch(32'h40, 1'b1, "pre_flush");
    @(posedge CLK); #1;
    imemREN  = 1'b1;
    imemaddr = 32'h40;
    iflush   = 1'b1;
    @(negedge CLK);
    chk("flush_ihit", 32'(ihit), 32'd0);
    chk("flush_load", imemload, 32'd0);
    @(posedge CLK); #1;
    iflush  = 1'b0;
    imemREN = 1'b0;

    // Flush during a fill; request withdrawn and address changed mid-fill.
    @(posedge CLK); #1;
    imemREN  = 1'b1;
    imemaddr = 32'h40;
    @(negedge CLK);
    chk("ff_miss", 32'(ihit), 32'd0);
    addr_q.push_back(32'h40);
    addr_q.push_back(32'h44);
    @(posedge CLK); #1;
    imemREN  = 1'b0;
    imemaddr = 32'h1234_5670;
    chk("ff_iren", 32'(iREN), 32'd1);
    chk("ff_iaddr0", iaddr, 32'h40);
    serve_fill("flush_fill", 1);
    fetch(32'h40, 1'b1, "after_fill_flush");

    // Reset in the middle of a fill.
    @(posedge CLK); #1;
    imemREN  = 1'b1;
    imemaddr = 32'h80;
    @(posedge CLK); #1;
    imemREN = 1'b0;
    chk("rmf_iren_before", 32'(iREN), 32'd1);
    @(posedge CLK); #2;
    nRST = 1'b0;
    #1;
    chk("rmf_iren", 32'(iREN), 32'd0);
    chk("rmf_ihit", 32'(ihit), 32'd0);
    chk("rmf_iaddr", iaddr, 32'd0);
    #10;
    nRST   = 1'b1;
    m_hits = 0;
    m_miss = 0;

    fetch(32'h40, 1'b1, "post_rst_40");
    fetch(32'h44, 1'b0, "post_rst_44");
    fetch(32'h440, 1'b1, "post_rst_440");
    fetch(32'h840, 1'b1, "post_rst_840");
    fetch(32'h844, 1'b0, "post_rst_844");

`ifdef ICACHE_STATS_EN
    chk("stat_miss", miss_count, 32'(m_miss));
    chk("stat_hit", hit_count, 32'(m_hits));
    chk("stat_miss3", miss_count, 32'd3);
    chk("stat_hit5", hit_count, 32'd5);
    force dut.r_hit_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_hit_cnt;
    fetch(32'h844, 1'b0, "sat_hit");
    chk("stat_hit_sat", hit_count, 32'hFFFF_FFFF);
    chk("stat_miss_keep", miss_count, 32'd3);
`endif

    if (exp_q.size() != 0) fail_now("scoreboard", "expected words left unconsumed");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
